// File: rtl/div_seq_32.sv
// Sequential 32-bit restoring divider for MIPS div/divu: operand capture,
// sign normalisation, 32 trial subtractions through one sub_32, sign fix-up.
module sub_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow
);
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module div_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_r, b_r, dvs, quo, rem, diff;
  logic        sgn_r, neg_q, neg_r, borrow, take, accept;
  logic [4:0]  cnt;
  logic [32:0] s;

  // rem's 33rd bit is always zero after an update (a restore only happens
  // when s[32] = 0), so only the low 32 bits are stored.
  assign s      = {rem, quo[31]};
  assign take   = s[32] | ~borrow;
  assign accept = start & ((state == IDLE) | (state == DONE));

  sub_32 u_sub (.a(s[31:0]), .b(dvs), .diff(diff), .borrow(borrow));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = (b_r == 32'h0) ? DONE : ITER;
      ITER:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (start) state_nxt = PREP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == PREP) | (state_nxt == ITER) | (state_nxt == FIX);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sgn_r       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= dividend;
        b_r   <= divisor;
        sgn_r <= is_signed;
      end
      case (state)
        PREP: begin
          neg_q <= sgn_r & (a_r[31] ^ b_r[31]);
          neg_r <= sgn_r & a_r[31];
          dvs   <= (sgn_r & b_r[31]) ? ~b_r + 32'd1 : b_r;
          quo   <= (sgn_r & a_r[31]) ? ~a_r + 32'd1 : a_r;
          rem   <= '0;
          cnt   <= '0;
          if (b_r == 32'h0) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= a_r;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          rem <= take ? diff : s[31:0];
          quo <= {quo[30:0], take};
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          quotient    <= neg_q ? -quo : quo;
          remainder   <= neg_r ? -rem : rem;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
